// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer around a Sobel core: streams an input frame from memory into the core and writes its results out.
// Optional drain watchdog enabled by defining SOBEL_CTRL_TIMEOUT_EN.
module sobel_frame_ctrl #(
    parameter int IMG_WIDTH     = 8,
    parameter int IMG_HEIGHT    = 8,
    parameter int DRAIN_TIMEOUT = 64,
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT,
    localparam int NOUT = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2),
    localparam int AW   = $clog2(NPIX),
    localparam int OW   = $clog2(NOUT + 1),
    localparam int WAW  = $clog2(NOUT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stall,
    output logic           rd_en,
    output logic [AW-1:0]  rd_addr,
    input  logic [7:0]     rd_data,
    output logic           core_start,
    output logic [7:0]     core_pixel_in,
    output logic           core_pixel_valid,
    input  logic [7:0]     core_pixel_out,
    input  logic           core_pixel_out_valid,
    output logic           wr_en,
    output logic [WAW-1:0] wr_addr,
    output logic [7:0]     wr_data,
    output logic           busy,
    output logic           frame_done,
    output logic           timeout_err,
    output logic [OW-1:0]  out_count
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t        state_q;
    logic [AW-1:0] rd_addr_q;
    logic [OW-1:0] out_count_q;
    logic [OW-1:0] out_count_d;
    logic          vld_p1_q;
    logic          armed_q;
    logic          busy_q;
    logic          frame_done_q;
    logic          last_rd;
    logic          out_full;

    assign rd_en    = (state_q == FEED) && !stall;
    assign last_rd  = rd_en && (rd_addr_q == AW'(NPIX - 1));
    assign out_full = (out_count_q == OW'(NOUT));

    // Writes are accepted in every active state, including FEED, until the frame is full.
    assign wr_en       = core_pixel_out_valid && (state_q != IDLE) && !out_full;
    assign out_count_d = out_count_q + OW'(wr_en);

    assign rd_addr          = rd_addr_q;
    assign core_pixel_valid = vld_p1_q;
    assign core_start       = vld_p1_q;
    assign core_pixel_in    = vld_p1_q ? rd_data : 8'h00;
    assign wr_addr          = out_count_q[WAW-1:0];
    assign wr_data          = core_pixel_out;
    assign busy             = busy_q;
    assign frame_done       = frame_done_q;
    assign out_count        = out_count_q;

`ifdef SOBEL_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic [TW-1:0] tmo_cnt_d;
    logic          tmo_hit;
    logic          timeout_err_q;

    assign tmo_cnt_d   = core_pixel_out_valid ? '0 : tmo_cnt_q + TW'(1);
    assign tmo_hit     = (state_q == DRAIN) && !core_pixel_out_valid &&
                         (tmo_cnt_q == TW'(DRAIN_TIMEOUT - 1));
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            out_count_q   <= '0;
            vld_p1_q      <= 1'b0;
            armed_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef SOBEL_CTRL_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            // armed_q keeps the first edge after reset release from accepting start.
            armed_q      <= 1'b1;
            vld_p1_q     <= rd_en;
            frame_done_q <= 1'b0;
            out_count_q  <= out_count_d;
`ifdef SOBEL_CTRL_TIMEOUT_EN
            tmo_cnt_q    <= (state_q == DRAIN) ? tmo_cnt_d : '0;
`endif
            case (state_q)
                IDLE: begin
                    if (start && armed_q) begin
                        state_q       <= FEED;
                        rd_addr_q     <= '0;
                        out_count_q   <= '0;
                        busy_q        <= 1'b1;
`ifdef SOBEL_CTRL_TIMEOUT_EN
                        timeout_err_q <= 1'b0;
`endif
                    end
                end
                FEED: begin
                    if (last_rd) begin
                        state_q <= DRAIN;
                    end else if (rd_en) begin
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                end
                DRAIN: begin
                    if (out_count_d == OW'(NOUT)) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
`ifdef SOBEL_CTRL_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        state_q       <= DONE;
                        frame_done_q  <= 1'b1;
                        timeout_err_q <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl: memory and Sobel core are modelled per cycle, expected pixels/writes are queued.
module tb_sobel_frame_ctrl;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - 2) * (H - 2);
    localparam int DTO  = 64;
    localparam int AW   = 6;
    localparam int OW   = 6;
    localparam int WAW  = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           stall;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [7:0]     rd_data;
    logic           core_start;
    logic [7:0]     core_pixel_in;
    logic           core_pixel_valid;
    logic [7:0]     core_pixel_out;
    logic           core_pixel_out_valid;
    logic           wr_en;
    logic [WAW-1:0] wr_addr;
    logic [7:0]     wr_data;
    logic           busy;
    logic           frame_done;
    logic           timeout_err;
    logic [OW-1:0]  out_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] pix_q[$];
    int         wa_q[$];
    logic [7:0] wd_q[$];

    sobel_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DRAIN_TIMEOUT(DTO)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .core_start(core_start), .core_pixel_in(core_pixel_in), .core_pixel_valid(core_pixel_valid),
        .core_pixel_out(core_pixel_out), .core_pixel_out_valid(core_pixel_out_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err), .out_count(out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pixval(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // One complete frame, checked cycle by cycle. Inputs change at negedge, outputs sampled 1 time unit later.
    task automatic run_frame(input int stall_at, input int stall_len, input int busy_start,
                             input int core_limit, input bit extra, input bit tmo_mode);
        int         exp_addr;
        bit         feeding;
        int         stall_left;
        bit         prev_rd;
        int         prev_addr;
        bit         exp_rd;
        bit         prev_exp_rd;
        int         pix_i;
        int         sched_n;
        bit         sched;
        logic [7:0] sched_val;
        bit         extra_done;
        int         exp_cnt;
        bit         wr_exp;
        bit         fd_exp;
        bit         fd_now;
        bit         fd_seen;
        int         fd_cnt;
        int         done_cyc;
        int         read_end;
        int         ea;
        logic [7:0] ed;
        exp_addr = 0; feeding = 0; stall_left = stall_len; prev_rd = 0; prev_addr = 0;
        prev_exp_rd = 0; pix_i = 0; sched_n = 0; sched = 0; sched_val = 8'h00; extra_done = 0;
        exp_cnt = 0; fd_exp = 0; fd_seen = 0; fd_cnt = 0; done_cyc = 0; read_end = -1;
        pix_q.delete(); wa_q.delete(); wd_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start = (cyc == 0) || (cyc == busy_start);
            if (cyc == 1) feeding = 1;
            stall = 1'b0;
            if (feeding && exp_addr == stall_at && stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end
            exp_rd = feeding && !stall;
            if (prev_rd) rd_data = pixval(prev_addr);
            core_pixel_out_valid = sched;
            core_pixel_out       = sched ? sched_val : 8'h00;
            wr_exp = 0;
            if (sched && exp_cnt < NOUT) begin
                wa_q.push_back(exp_cnt);
                wd_q.push_back(sched_val);
                exp_cnt++;
                wr_exp = 1;
            end
            #1;
            checks++;
            if (rd_en !== exp_rd) begin
                errors++; $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, exp_rd);
            end
            if (feeding) begin
                checks++;
                if (rd_addr !== AW'(exp_addr)) begin
                    errors++; $display("FAIL rd_addr cyc=%0d got=%0d exp=%0d", cyc, rd_addr, exp_addr);
                end
            end
            checks++;
            if (core_pixel_valid !== prev_exp_rd) begin
                errors++; $display("FAIL core_pixel_valid cyc=%0d got=%b exp=%b", cyc, core_pixel_valid, prev_exp_rd);
            end
            checks++;
            if (core_start !== core_pixel_valid) begin
                errors++; $display("FAIL core_start cyc=%0d got=%b exp=%b", cyc, core_start, core_pixel_valid);
            end
            if (core_pixel_valid === 1'b1) begin
                checks++;
                if (pix_q.size() == 0) begin
                    errors++; $display("FAIL core_pixel_unexpected cyc=%0d got=%0h exp=none", cyc, core_pixel_in);
                end else begin
                    ed = pix_q.pop_front();
                    if (core_pixel_in !== ed) begin
                        errors++; $display("FAIL core_pixel_in cyc=%0d got=%0h exp=%0h", cyc, core_pixel_in, ed);
                    end
                end
            end
            checks++;
            if (wr_en !== wr_exp) begin
                errors++; $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, wr_en, wr_exp);
            end
            if (wr_en === 1'b1 && wa_q.size() > 0) begin
                ea = wa_q.pop_front();
                ed = wd_q.pop_front();
                checks++;
                if (wr_addr !== WAW'(ea) || wr_data !== ed) begin
                    errors++; $display("FAIL write cyc=%0d got=%0d/%0h exp=%0d/%0h", cyc, wr_addr, wr_data, ea, ed);
                end
            end
            fd_now = tmo_mode ? (read_end >= 0 && cyc == read_end + 1 + DTO) : fd_exp;
            checks++;
            if (frame_done !== fd_now) begin
                errors++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, fd_now);
            end
            checks++;
            if (busy !== ((cyc >= 1) && !fd_seen)) begin
                errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc >= 1) && !fd_seen);
            end
            if (frame_done === 1'b1) begin
                if (!fd_seen) done_cyc = cyc;
                fd_seen = 1;
                fd_cnt++;
            end
            fd_exp = !tmo_mode && wr_exp && (exp_cnt == NOUT);
            if (exp_rd) begin
                pix_q.push_back(pixval(exp_addr));
                if (exp_addr == NPIX - 1) begin
                    feeding  = 0;
                    read_end = cyc;
                end else begin
                    exp_addr++;
                end
            end
            prev_exp_rd = exp_rd;
            prev_rd     = (rd_en === 1'b1);
            prev_addr   = int'(rd_addr);
            // Core model: pixels with row>=2 and col>=2 complete a 3x3 window, one output a cycle later.
            sched = 0;
            if (prev_exp_rd_valid(core_pixel_valid)) begin
                if (pix_i / W >= 2 && pix_i % W >= 2 && sched_n < core_limit) begin
                    sched     = 1;
                    sched_val = pixval(pix_i) ^ 8'h5A;
                    sched_n++;
                end
                pix_i++;
            end else if (extra && !extra_done && sched_n == NOUT) begin
                sched      = 1;
                sched_val  = 8'hEE;
                extra_done = 1;
            end
            if (fd_seen && cyc >= done_cyc + 2) break;
        end
        @(negedge clk);
        start = 0; stall = 0; core_pixel_out_valid = 0; core_pixel_out = 8'h00;
        #1;
        checks++;
        if (!fd_seen || fd_cnt != 1) begin
            errors++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt);
        end
        checks++;
        if (out_count !== OW'(exp_cnt)) begin
            errors++; $display("FAIL out_count got=%0d exp=%0d", out_count, exp_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_after got=%b exp=0", busy);
        end
        checks++;
        if (timeout_err !== tmo_mode) begin
            errors++; $display("FAIL timeout_err got=%b exp=%b", timeout_err, tmo_mode);
        end
        checks++;
        if (pix_q.size() != 0 || wa_q.size() != 0) begin
            errors++; $display("FAIL leftover got=%0d/%0d exp=0/0", pix_q.size(), wa_q.size());
        end
    endtask

    function automatic bit prev_exp_rd_valid(input logic v);
        return v === 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1; start = 1; stall = 0; rd_data = 8'hFF;
        core_pixel_out_valid = 1; core_pixel_out = 8'h33;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({rd_en, core_start, core_pixel_valid, wr_en, busy, frame_done, timeout_err} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=0",
                {rd_en, core_start, core_pixel_valid, wr_en, busy, frame_done, timeout_err});
        end
        checks++;
        if (core_pixel_in !== 8'h00 || rd_addr !== '0 || out_count !== '0) begin
            errors++; $display("FAIL reset_data got=%0h/%0d/%0d exp=0/0/0", core_pixel_in, rd_addr, out_count);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++; $display("FAIL start_at_release got=%b/%b exp=0/0", busy, rd_en);
        end
        start = 0; core_pixel_out_valid = 0; core_pixel_out = 8'h00;
    endtask

    task automatic test_nominal();
        run_frame(-1, 0, -1, NOUT, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_frame(20, 5, -1, NOUT, 1'b0, 1'b0);
    endtask

    task automatic test_start_busy();
        run_frame(-1, 0, 10, NOUT, 1'b0, 1'b0);
    endtask

    task automatic test_excess();
        run_frame(-1, 0, -1, NOUT, 1'b1, 1'b0);
        @(negedge clk);
        core_pixel_out_valid = 1; core_pixel_out = 8'h77;
        #1;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL idle_wr_en got=%b exp=0", wr_en);
        end
        @(negedge clk);
        core_pixel_out_valid = 0; core_pixel_out = 8'h00;
        #1;
        checks++;
        if (out_count !== OW'(NOUT)) begin
            errors++; $display("FAIL idle_out_count got=%0d exp=%0d", out_count, NOUT);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 0;
        @(negedge clk);
        start = 1; stall = 0; core_pixel_out_valid = 0;
        @(negedge clk);
        start = 0;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (rd_addr === AW'(30)) begin
                hit = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL reach_addr30 got=%0d exp=30", rd_addr);
        end
        rst = 1; rd_data = 8'hA5;
        #1;
        checks++;
        if ({rd_en, core_start, core_pixel_valid, wr_en, busy, frame_done, timeout_err} !== 7'b0 ||
            core_pixel_in !== 8'h00) begin
            errors++; $display("FAIL reset_mid_async got=%b/%0h exp=0/0",
                {rd_en, core_start, core_pixel_valid, wr_en, busy, frame_done, timeout_err}, core_pixel_in);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || core_pixel_valid !== 1'b0 || rd_addr !== '0 || out_count !== '0) begin
            errors++; $display("FAIL reset_mid_next got=%b%b%b/%0d/%0d exp=000/0/0",
                busy, rd_en, core_pixel_valid, rd_addr, out_count);
        end
        @(negedge clk);
        rst = 0; start = 1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL release_start got=%b exp=0", busy);
        end
        start = 0;
        run_frame(-1, 0, -1, NOUT, 1'b0, 1'b0);
    endtask

`ifdef SOBEL_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        run_frame(-1, 0, -1, 10, 1'b0, 1'b1);
    endtask
`endif

    initial begin
        rst = 1; start = 0; stall = 0; rd_data = 8'h00;
        core_pixel_out = 8'h00; core_pixel_out_valid = 0;
        test_reset();
        test_nominal();
        test_stall();
        test_start_busy();
        test_excess();
        test_reset_mid();
`ifdef SOBEL_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 8, meaning pixels per input row (>=3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 8, meaning rows per input frame (>=3).
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 64, meaning the maximum number of DRAIN cycles without a core output.
REQ-004 SHALL use localparam NPIX = IMG_WIDTH*IMG_HEIGHT, NOUT = (IMG_WIDTH-2)*(IMG_HEIGHT-2), AW = $clog2(NPIX), OW = $clog2(NOUT+1).
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, frame request, sampled in IDLE only.
REQ-008 SHALL have port stall, input, 1, pauses pixel fetch while high.
REQ-009 SHALL have ports rd_en (output, 1), rd_addr (output, AW) and rd_data (input, 8), forming the input frame memory with 1-cycle read latency.
REQ-010 SHALL have ports core_start (output, 1), core_pixel_in (output, 8) and core_pixel_valid (output, 1), driving the Sobel core input.
REQ-011 SHALL have ports core_pixel_out (input, 8) and core_pixel_out_valid (input, 1), carrying the Sobel core result.
REQ-012 SHALL have ports wr_en (output, 1), wr_addr (output, $clog2(NOUT)) and wr_data (output, 8), forming the output frame memory write port.
REQ-013 SHALL have outputs busy (1), frame_done (1, pulse), timeout_err (1, sticky) and out_count (OW).

Function
REQ-014 SHALL implement states IDLE, FEED, DRAIN and DONE.
REQ-015 SHALL move from IDLE to FEED on start=1, clearing rd_addr, out_count and timeout_err.
REQ-016 SHALL ignore start in every state except IDLE.
REQ-017 SHALL, in FEED with stall=0, assert rd_en with the current rd_addr and then increment rd_addr; with stall=1, rd_en SHALL be 0 and rd_addr SHALL hold.
REQ-018 SHALL drive core_pixel_valid as rd_en delayed by one cycle, with core_pixel_in = rd_data in that cycle, giving a fixed latency of 1 cycle.
REQ-019 SHALL drive core_start equal to core_pixel_valid.
REQ-020 SHALL transition FEED->DRAIN in the cycle after the read of address NPIX-1 is issued; no further rd_en is issued after that read.
REQ-021 SHALL, on each core_pixel_out_valid with out_count<NOUT (in any non-IDLE state), assert wr_en combinationally with wr_addr=out_count and wr_data=core_pixel_out, and increment out_count on that edge.
REQ-022 SHALL suppress wr_en and not count core_pixel_out_valid when out_count==NOUT or the state is IDLE.
REQ-023 SHALL move DRAIN->DONE when out_count reaches NOUT, including the case where the final write occurs in that same cycle.
REQ-024 SHALL hold DONE for exactly one cycle, with frame_done=1 in that cycle, and then return to IDLE.
REQ-025 SHALL hold busy=1 in FEED, DRAIN and DONE, and busy=0 in IDLE.
REQ-026 SHALL hold out_count at its final value in IDLE until the next accepted start.
REQ-027 SHALL allow core outputs to arrive during FEED; these outputs are written and counted normally.

Reset
REQ-028 SHALL, on rst=1 at any time including mid-frame, enter IDLE immediately, clear rd_addr, out_count and the valid pipeline, and hold the outputs rd_en, core_start, core_pixel_valid, wr_en, busy, frame_done and timeout_err at 0 and core_pixel_in at 0.
REQ-029 SHALL start no frame in the cycle rst deasserts, even if start=1; start is then sampled from the next edge.

Configuration
REQ-030 SHALL, with SOBEL_CTRL_TIMEOUT_EN defined, count consecutive DRAIN cycles without core_pixel_out_valid (the counter is reset by each valid); on reaching DRAIN_TIMEOUT it SHALL set timeout_err=1 and go to DONE, where frame_done pulses normally.
REQ-031 SHALL, with SOBEL_CTRL_TIMEOUT_EN undefined, wait indefinitely in DRAIN, tie timeout_err to 0, and contain no timeout counter.

Verification
REQ-032 SHALL cover a nominal 8x8 frame: start pulse -> 64 rd_en cycles at addresses 0..63, core_pixel_valid lagging by 1 cycle, 36 writes at wr_addr 0..35, frame_done pulsing once, then busy=0 and out_count=36.
REQ-033 SHALL cover stall: stall=1 for 5 cycles at rd_addr=20 -> rd_addr holds at 20, core_pixel_valid shows a 5-cycle gap, and all 64 pixels are delivered in order.
REQ-034 SHALL cover start while busy: a start pulse during FEED -> no restart, and the addresses continue monotonically.
REQ-035 SHALL cover reset mid-frame: rst at rd_addr=30 -> IDLE with all outputs 0 the next cycle, and a subsequent start begins again from address 0.
REQ-036 SHALL cover excess outputs: a 37th core_pixel_out_valid -> no wr_en, and out_count stays 36.
REQ-037 SHALL cover timeout: with SOBEL_CTRL_TIMEOUT_EN defined, the core stops after 10 outputs -> timeout_err=1 64 cycles into DRAIN, frame_done pulses, and out_count=10.
